// File: rtl/hamming_decoder_if.sv
// Byte-in / word-out handshake bundle for the SECDED Hamming decoder.
interface hamming_decoder_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] out_data;
  logic [3:0]  out_syn;
  logic [1:0]  out_status;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  in_byte, in_valid, out_ready,
    output in_ready, out_data, out_syn, out_status, out_valid
  );

  modport master (
    output in_byte, in_valid, out_ready,
    input  in_ready, out_data, out_syn, out_status, out_valid
  );
endinterface

// File: rtl/hamming_decoder.sv
// Byte-serial SECDED (16,11) Hamming decoder: high byte then low byte in, data+status out.
// Optional saturating error counters are built when HAMMING_ERR_CNT_EN is defined.
module hamming_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync,
  hamming_decoder_if.slave bus,
  output logic [CNT_W-1:0] sec_cnt,
  output logic [CNT_W-1:0] ded_cnt
);
  typedef enum logic [1:0] {WAIT_HI, WAIT_LO, OUT} state_e;

  state_e      state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [10:0] data_q, data_d;
  logic [3:0]  syn_q, syn_d;
  logic [1:0]  st_q, st_d;

  logic [15:0] cw, fix;
  logic [3:0]  syn;
  logic        par;
  logic [1:0]  st;
  logic [10:0] dec;
  logic        in_rdy, out_vld, load;

  // Word bit i is codeword position i, so syndrome masks follow the index bits.
  always_comb begin
    cw     = {hi_q, bus.in_byte};
    syn[0] = ^(cw & 16'hAAAA);
    syn[1] = ^(cw & 16'hCCCC);
    syn[2] = ^(cw & 16'hF0F0);
    syn[3] = ^(cw & 16'hFF00);
    par    = ^cw;
    fix    = cw;
    if (par) fix[syn] = ~cw[syn];
    dec    = {fix[15:9], fix[7:5], fix[3]};
    if (par)            st = 2'b01;
    else if (syn != '0) st = 2'b10;
    else                st = 2'b00;
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    load    = 1'b0;
    case (state_q)
      WAIT_HI: begin
        in_rdy = 1'b1;
        if (bus.in_valid) begin
          hi_d    = bus.in_byte;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        in_rdy = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        out_vld = 1'b1;
        if (bus.out_ready) state_d = WAIT_HI;
      end
      default: state_d = WAIT_HI;
    endcase
    // Flush wins over any handshake in flight, including a low-byte accept.
    if (sync) begin
      state_d = WAIT_HI;
      hi_d    = '0;
      load    = 1'b0;
    end
  end

  always_comb begin
    data_d = load ? dec : data_q;
    syn_d  = load ? syn : syn_q;
    st_d   = load ? st  : st_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_HI;
      hi_q    <= '0;
      data_q  <= '0;
      syn_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      syn_q   <= syn_d;
      st_q    <= st_d;
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = out_vld;
  assign bus.out_data   = data_q;
  assign bus.out_syn    = syn_q;
  assign bus.out_status = st_q;

`ifdef HAMMING_ERR_CNT_EN
  logic [CNT_W-1:0] sec_q, sec_d, ded_q, ded_d;

  always_comb begin
    sec_d = sec_q;
    ded_d = ded_q;
    if (load && st == 2'b01 && sec_q != '1) sec_d = sec_q + 1'b1;
    if (load && st == 2'b10 && ded_q != '1) ded_d = ded_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_q <= '0;
      ded_q <= '0;
    end else begin
      sec_q <= sec_d;
      ded_q <= ded_d;
    end
  end

  assign sec_cnt = sec_q;
  assign ded_cnt = ded_q;
`else
  assign sec_cnt = '0;
  assign ded_cnt = '0;
`endif
endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard bench for hamming_decoder: expectations queued at drive time, checked on output handshake.
module tb_hamming_decoder;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic [10:0]      d;
    logic [3:0]       s;
    logic [1:0]       st;
    logic [CNT_W-1:0] sec;
    logic [CNT_W-1:0] ded;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sync = 1'b0;
  logic [CNT_W-1:0] sec_cnt, ded_cnt;
  hamming_decoder_if bus();

  hamming_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .sync(sync), .bus(bus),
    .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  exp_t sbq[$];
  exp_t mon_e;
  int sec_m = 0;
  int ded_m = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] w;
    logic p;
    w = '0;
    w[3] = d[0];
    w[7:5] = d[3:1];
    w[15:9] = d[10:4];
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int i = 1; i < 16; i++) if ((i >> k) & 1) p ^= w[i];
      w[1 << k] = p;
    end
    w[0] = ^w;
    return w;
  endfunction

  task automatic push_exp(input logic [10:0] d, input logic [3:0] s, input logic [1:0] st);
    exp_t e;
    if (st == 2'b01 && sec_m < CMAX) sec_m++;
    if (st == 2'b10 && ded_m < CMAX) ded_m++;
    e.d = d; e.s = s; e.st = st;
`ifdef HAMMING_ERR_CNT_EN
    e.sec = CNT_W'(sec_m); e.ded = CNT_W'(ded_m);
`else
    e.sec = '0; e.ded = '0;
`endif
    sbq.push_back(e);
  endtask

  // Independent reference: syndrome as XOR of set-bit positions.
  task automatic push_model(input logic [15:0] w);
    logic [3:0] s;
    logic [15:0] c;
    logic [1:0] st;
    s = '0;
    for (int i = 1; i < 16; i++) if (w[i]) s ^= 4'(i);
    c = w;
    if (^w) c[s] = ~c[s];
    st = (^w) ? 2'b01 : ((s != 0) ? 2'b10 : 2'b00);
    push_exp({c[15:9], c[7:5], c[3]}, s, st);
  endtask

  task automatic put_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_byte = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] hi, input logic [7:0] lo);
    put_byte(hi);
    put_byte(lo);
    chk("latency_valid", 32'(bus.out_valid), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("drain_timeout", sbq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        mon_e = sbq.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(mon_e.d));
        chk("out_syn", 32'(bus.out_syn), 32'(mon_e.s));
        chk("out_status", 32'(bus.out_status), 32'(mon_e.st));
        chk("sec_cnt", 32'(sec_cnt), 32'(mon_e.sec));
        chk("ded_cnt", 32'(ded_cnt), 32'(mon_e.ded));
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_out_data"}, 32'(bus.out_data), 0);
    chk({tag, "_out_syn"}, 32'(bus.out_syn), 0);
    chk({tag, "_out_status"}, 32'(bus.out_status), 0);
    chk({tag, "_sec_cnt"}, 32'(sec_cnt), 0);
    chk({tag, "_ded_cnt"}, 32'(ded_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int p1, p2, nf;
    bus.in_byte = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #2 chk_reset_vals("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed vectors with literal expectations
    push_exp(11'h5A3, 4'd0, 2'b00);  send_word(8'hB4, 8'h2D); drain();
    push_exp(11'h5A3, 4'd6, 2'b01);  send_word(8'hB4, 8'h6D); drain();
    push_exp(11'h5A3, 4'd0, 2'b01);  send_word(8'hB4, 8'h2C); drain();
    push_exp(11'h5B7, 4'd15, 2'b10); send_word(8'hB6, 8'h6D); drain();

    // Backpressure: result held, input blocked, stray in_valid ignored
    bus.out_ready = 1'b0;
    push_exp(11'h5A3, 4'd0, 2'b00);
    send_word(8'hB4, 8'h2D);
    bus.in_byte = 8'hFF;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_data", 32'(bus.out_data), 32'(sbq[0].d));
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Flush after the high byte only
    put_byte(8'h00);
    sync = 1'b1;
    @(posedge clk);
    #1 sync = 1'b0;
    push_exp(11'h5A3, 4'd0, 2'b00);
    send_word(8'hB4, 8'h2D);
    drain();

    // Flush while holding a result drops out_valid
    bus.out_ready = 1'b0;
    put_byte(8'hB4);
    put_byte(8'h2D);
    chk("sync_pre_valid", 32'(bus.out_valid), 1);
    sync = 1'b1;
    @(posedge clk);
    #1 sync = 1'b0;
    chk("sync_drop_valid", 32'(bus.out_valid), 0);
    chk("sync_in_ready", 32'(bus.in_ready), 1);
    bus.out_ready = 1'b1;

    // Random words with 0, 1 or 2 flipped bits
    for (int n = 0; n < 10; n++) begin
      w = enc(11'($urandom));
      nf = $urandom_range(0, 2);
      p1 = $urandom_range(0, 15);
      p2 = (p1 + $urandom_range(1, 15)) % 16;
      if (nf >= 1) w[p1] = ~w[p1];
      if (nf == 2) w[p2] = ~w[p2];
      push_model(w);
      send_word(w[15:8], w[7:0]);
      drain();
    end

    // Saturation of the corrected-error counter
    for (int n = 0; n < 5; n++) begin
      w = enc(11'($urandom));
      p1 = $urandom_range(0, 15);
      w[p1] = ~w[p1];
      push_model(w);
      send_word(w[15:8], w[7:0]);
      drain();
    end
    @(negedge clk);
`ifdef HAMMING_ERR_CNT_EN
    chk("sec_saturated", 32'(sec_cnt), CMAX);
`else
    chk("sec_tied_zero", 32'(sec_cnt), 0);
`endif

    // Asynchronous reset mid-word
    put_byte(8'h12);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    sec_m = 0;
    ded_m = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    push_exp(11'h5A3, 4'd0, 2'b00);
    send_word(8'hB4, 8'h2D);
    drain();

    repeat (3) @(negedge clk);
    chk("queue_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
